// File: rtl/reg_sb_pkg.sv
// rtl/reg_sb_pkg.sv - shared types and helpers for the register-hazard scoreboard
package reg_sb_pkg;

  // Entry address field is sized for the widest supported register file.
  localparam int unsigned ADDR_W_MAX = 8;
  localparam int unsigned REG_ZERO   = 0;

  typedef struct packed {
    logic                  valid;
    logic                  is_load;
    logic [ADDR_W_MAX-1:0] addr;
  } sb_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - ID-stage decode inputs and hazard outputs of the scoreboard
interface reg_scoreboard_if
  import reg_sb_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int READ_PORTS = 2,
  parameter int DEPTH      = 3,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = sel_w(DEPTH)
);

  logic                         id_valid;
  logic [READ_PORTS-1:0]        id_read_en;
  logic [READ_PORTS*ADDR_W-1:0] id_read_addr;
  logic                         id_write_en;
  logic [ADDR_W-1:0]            id_write_addr;
  logic                         id_is_load;
  logic                         flush;
  logic                         pipe_hold;
  logic                         id_stall;
  logic [READ_PORTS*SEL_W-1:0]  fwd_sel;
  logic [CNT_W-1:0]             stall_cnt;

  modport master (
    output id_valid, id_read_en, id_read_addr, id_write_en, id_write_addr,
           id_is_load, flush, pipe_hold,
    input  id_stall, fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_read_en, id_read_addr, id_write_en, id_write_addr,
           id_is_load, flush, pipe_hold,
    output id_stall, fwd_sel, stall_cnt
  );

endinterface

// File: rtl/reg_sb_match.sv
// rtl/reg_sb_match.sv - per-read-port priority match against in-flight destinations
module reg_sb_match
  import reg_sb_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = sel_w(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic                  read_en,
  input  logic [ADDR_W-1:0]     read_addr,
  output logic [SEL_W-1:0]      sel,
  output logic                  hazard
);

  logic found;
  logic active;

  assign active = read_en && (read_addr != ADDR_W'(REG_ZERO));

  // entries[0] is stage 1; the first hit is the youngest producer and masks older ones.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && active && entries[k].valid &&
          entries[k].addr == ADDR_W_MAX'(read_addr)) begin
        found  = 1'b1;
        sel    = SEL_W'(k + 1);
        hazard = entries[k].is_load && ((k + 1) < LOAD_READY);
      end
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - ID-stage load-use stall and forwarding-select generator
module reg_scoreboard
  import reg_sb_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int READ_PORTS = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = sel_w(DEPTH)
) (
  input logic             clk,
  input logic             rst_n,
  reg_scoreboard_if.slave sb
);

  sb_entry_t [DEPTH-1:0]       entries_q;
  sb_entry_t                   issue;
  logic [READ_PORTS-1:0]       port_hazard;
  logic [READ_PORTS*SEL_W-1:0] fwd_sel;
  logic                        hazard;
  logic                        stall;
  logic [CNT_W-1:0]            cnt_q;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    reg_sb_match #(
      .ADDR_W     (ADDR_W),
      .DEPTH      (DEPTH),
      .LOAD_READY (LOAD_READY),
      .SEL_W      (SEL_W)
    ) u_match (
      .entries   (entries_q),
      .read_en   (sb.id_read_en[p]),
      .read_addr (sb.id_read_addr[p*ADDR_W +: ADDR_W]),
      .sel       (fwd_sel[p*SEL_W +: SEL_W]),
      .hazard    (port_hazard[p])
    );
  end

  assign hazard = |port_hazard;
  assign stall  = sb.id_valid && hazard && !sb.flush;

  // Stalled or flushed instructions enter the pipe as bubbles; r0 writes are never tracked.
  always_comb begin
    issue = '0;
    if (sb.id_valid && !stall && !sb.flush && sb.id_write_en &&
        sb.id_write_addr != ADDR_W'(REG_ZERO)) begin
      issue.valid   = 1'b1;
      issue.is_load = sb.id_is_load;
      issue.addr    = ADDR_W_MAX'(sb.id_write_addr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q <= '0;
    end else if (!sb.pipe_hold) begin
      entries_q[0] <= issue;
      for (int k = 1; k < DEPTH; k++) begin
        entries_q[k] <= entries_q[k-1];
      end
    end
  end

  // Counts real stall cycles even while downstream is holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sb.id_stall  = stall;
  assign sb.fwd_sel   = fwd_sel;
  assign sb.stall_cnt = cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  reg_scoreboard_if #(.ADDR_W(5), .READ_PORTS(2), .DEPTH(3), .CNT_W(16)) sb_if ();

  reg_scoreboard #(
    .ADDR_W(5), .READ_PORTS(2), .DEPTH(3), .LOAD_READY(2), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [1:0] ren, input logic [4:0] ra0,
                       input logic [4:0] ra1, input logic we, input logic [4:0] wa,
                       input logic ld);
    sb_if.id_valid      = v;
    sb_if.id_read_en    = ren;
    sb_if.id_read_addr  = {ra1, ra0};
    sb_if.id_write_en   = we;
    sb_if.id_write_addr = wa;
    sb_if.id_is_load    = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic stall, input logic [3:0] fwd,
                            input logic [15:0] cnt);
    #1;
    check({tag, ".stall"}, 32'(sb_if.id_stall), 32'(stall));
    check({tag, ".fwd"},   32'(sb_if.fwd_sel),  32'(fwd));
    check({tag, ".cnt"},   32'(sb_if.stall_cnt), 32'(cnt));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sb_if.flush     = 1'b0;
    sb_if.pipe_hold = 1'b0;
    instr(0, 2'b00, 0, 0, 0, 0, 0);
    #12;
    expect_out("reset", 0, 4'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ADDIU $3 ; ADDU $4,$3,$3
    instr(1, 2'b01, 0, 0, 1, 3, 0);
    expect_out("addiu3", 0, 4'h0, 16'd0);
    step();
    instr(1, 2'b11, 3, 3, 1, 4, 0);
    expect_out("addu4_fwd1", 0, 4'b0101, 16'd0);
    step();

    // LW $5 ; ADDU $6,$5,$0
    instr(1, 2'b01, 0, 0, 1, 5, 1);
    expect_out("lw5", 0, 4'h0, 16'd0);
    step();
    instr(1, 2'b11, 5, 0, 1, 6, 0);
    expect_out("loaduse_stall", 1, 4'b0001, 16'd0);
    step();
    expect_out("loaduse_fwd2", 0, 4'b0010, 16'd1);
    step();

    // ORI $7 ; LW $7 ; ADDU $8,$7,$6
    instr(1, 2'b01, 0, 0, 1, 7, 0);
    expect_out("ori7", 0, 4'h0, 16'd1);
    step();
    instr(1, 2'b01, 0, 0, 1, 7, 1);
    expect_out("lw7", 0, 4'h0, 16'd1);
    step();
    instr(1, 2'b11, 7, 6, 1, 8, 0);
    expect_out("youngest_load", 1, 4'b1101, 16'd1);
    step();
    expect_out("youngest_fwd2", 0, 4'b0010, 16'd2);
    step();

    // write $0, then read $0 and $8
    instr(1, 2'b00, 0, 0, 1, 0, 0);
    expect_out("wr_r0", 0, 4'h0, 16'd2);
    step();
    instr(1, 2'b11, 0, 8, 0, 0, 0);
    expect_out("rd_r0", 0, 4'b1000, 16'd2);
    step();

    // flush beats load-use hazard and leaves a bubble
    instr(1, 2'b01, 0, 0, 1, 9, 1);
    step();
    sb_if.flush = 1'b1;
    instr(1, 2'b01, 9, 0, 1, 10, 0);
    expect_out("flush_nostall", 0, 4'b0001, 16'd2);
    step();
    sb_if.flush = 1'b0;
    instr(1, 2'b11, 10, 9, 0, 0, 0);
    expect_out("flush_bubble", 0, 4'b1000, 16'd2);
    step();

    // pipe_hold freezes entries, counter still advances
    instr(1, 2'b01, 0, 0, 1, 11, 1);
    step();
    sb_if.pipe_hold = 1'b1;
    instr(1, 2'b01, 11, 0, 1, 12, 0);
    expect_out("hold0", 1, 4'b0001, 16'd2);
    step();
    expect_out("hold1", 1, 4'b0001, 16'd3);
    step();
    expect_out("hold2", 1, 4'b0001, 16'd4);
    step();
    expect_out("hold3", 1, 4'b0001, 16'd5);
    sb_if.pipe_hold = 1'b0;
    step();
    expect_out("hold_release", 0, 4'b0010, 16'd6);
    step();

    // saturate the counter with a held load-use stall
    instr(1, 2'b01, 0, 0, 1, 13, 1);
    step();
    sb_if.pipe_hold = 1'b1;
    instr(1, 2'b01, 13, 0, 1, 14, 0);
    repeat (65529) @(posedge clk);
    #1;
    expect_out("sat_reach", 1, 4'b0001, 16'hFFFF);
    step();
    step();
    expect_out("sat_hold", 1, 4'b0001, 16'hFFFF);

    // asynchronous reset mid-stall
    #1;
    rst_n = 1'b0;
    expect_out("async_reset", 0, 4'h0, 16'h0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_out("after_reset", 0, 4'h0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
